// File: rtl/dec_stage.sv
// Instruction-decode stage: IR latch, field split, immediate extension and a 2R/1W register file.
// Optional macro DEC_BYPASS_EN selects write-first forwarding into RF_A/RF_B (default: read-first).
module dec_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              IR_LdEn,
  input  logic              Flush,
  input  logic [1:0]        ImmExt,
  input  logic              RF_WrEn,
  input  logic [4:0]        RF_WrAddr,
  input  logic [DATA_W-1:0] RF_WrData,
  output logic [5:0]        Opcode,
  output logic [5:0]        Funct,
  output logic [4:0]        Rd,
  output logic [4:0]        Rt,
  output logic [DATA_W-1:0] Immed,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic              Instr_valid
);

  logic [31:0]       ir_q, ir_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] rf_a_q, rf_a_d;
  logic [DATA_W-1:0] rf_b_q, rf_b_d;
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];
  logic [4:0]        rs, rt;

  // Mode 11 falls back to sign extension; mode 10 parks the immediate at [31:16].
  function automatic logic [DATA_W-1:0] imm_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic [DATA_W-1:0] r;
    case (mode)
      2'b01:   r = {{(DATA_W-16){1'b0}}, imm};
      2'b10:   r = {{(DATA_W-16){1'b0}}, imm} << 16;
      default: r = {{(DATA_W-16){imm[15]}}, imm};
    endcase
    return r;
  endfunction

  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];

  always_comb begin
    ir_d  = ir_q;
    vld_d = vld_q;
    if (Flush) begin
      ir_d  = '0;
      vld_d = 1'b0;
    end else if (IR_LdEn) begin
      ir_d  = Instr;
      vld_d = 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (RF_WrEn && RF_WrAddr != 5'd0) regs_d[RF_WrAddr] = RF_WrData;
  end

  // Operands are re-read every edge so they follow later writes to the same register.
  always_comb begin
    rf_a_d = (rs == 5'd0) ? '0 : regs_q[rs];
    rf_b_d = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef DEC_BYPASS_EN
    if (RF_WrEn && RF_WrAddr != 5'd0 && RF_WrAddr == rs) rf_a_d = RF_WrData;
    if (RF_WrEn && RF_WrAddr != 5'd0 && RF_WrAddr == rt) rf_b_d = RF_WrData;
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir_q   <= '0;
      vld_q  <= 1'b0;
      rf_a_q <= '0;
      rf_b_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      ir_q   <= ir_d;
      vld_q  <= vld_d;
      rf_a_q <= rf_a_d;
      rf_b_q <= rf_b_d;
      regs_q <= regs_d;
    end
  end

  assign Opcode      = ir_q[31:26];
  assign Funct       = ir_q[5:0];
  assign Rd          = ir_q[15:11];
  assign Rt          = rt;
  assign Immed       = imm_ext(ir_q[15:0], ImmExt);
  assign RF_A        = rf_a_q;
  assign RF_B        = rf_b_q;
  assign Instr_valid = vld_q;

endmodule

// File: tb/tb_dec_stage.sv
// Scoreboard bench for dec_stage: a stimulus process updates an abstract register-file model
// and queues expected outputs; a monitor pops and compares on each falling edge.
module tb_dec_stage;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [31:0]   Instr;
  logic          IR_LdEn, Flush, RF_WrEn;
  logic [1:0]    ImmExt;
  logic [4:0]    RF_WrAddr;
  logic [DW-1:0] RF_WrData;
  logic [5:0]    Opcode, Funct;
  logic [4:0]    Rd, Rt;
  logic [DW-1:0] Immed, RF_A, RF_B;
  logic          Instr_valid;

  dec_stage #(.DATA_W(DW), .REG_CNT(32)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .IR_LdEn(IR_LdEn), .Flush(Flush),
    .ImmExt(ImmExt), .RF_WrEn(RF_WrEn), .RF_WrAddr(RF_WrAddr), .RF_WrData(RF_WrData),
    .Opcode(Opcode), .Funct(Funct), .Rd(Rd), .Rt(Rt), .Immed(Immed),
    .RF_A(RF_A), .RF_B(RF_B), .Instr_valid(Instr_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  op, fn;
    logic [4:0]  rd, rt;
    logic [31:0] imm, a, b;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_ir;
  logic        m_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] mode);
    if (mode == 2'b01) return 32'(imm);
    if (mode == 2'b10) return 32'(imm) * 32'd65536;
    return 32'($signed(imm));
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] r;
    r = (a == 0) ? 32'h0 : m_regs[a];
`ifdef DEC_BYPASS_EN
    if (we && wa == a && wa != 0) r = wd;
`endif
    return r;
  endfunction

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("opcode", 32'(Opcode), 32'(e.op));
      chk("funct",  32'(Funct),  32'(e.fn));
      chk("rd",     32'(Rd),     32'(e.rd));
      chk("rt",     32'(Rt),     32'(e.rt));
      chk("immed",  Immed,       e.imm);
      chk("rf_a",   RF_A,        e.a);
      chk("rf_b",   RF_B,        e.b);
      chk("valid",  32'(Instr_valid), 32'(e.v));
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ir = 32'h0;
    m_v  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, queue the post-edge outputs.
  task automatic step(input logic [31:0] ins, input logic ld, input logic fl, input logic [1:0] ie,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    Instr = ins; IR_LdEn = ld; Flush = fl; ImmExt = ie;
    RF_WrEn = we; RF_WrAddr = wa; RF_WrData = wd;
    @(posedge Clk);
    e.a = ref_read(m_ir[25:21], we, wa, wd);
    e.b = ref_read(m_ir[20:16], we, wa, wd);
    if (we && wa != 0) m_regs[wa] = wd;
    if (fl) begin
      m_ir = 32'h0; m_v = 1'b0;
    end else if (ld) begin
      m_ir = ins; m_v = 1'b1;
    end
    e.op  = m_ir[31:26];
    e.fn  = m_ir[5:0];
    e.rd  = m_ir[15:11];
    e.rt  = m_ir[20:16];
    e.imm = ref_imm(m_ir[15:0], ie);
    e.v   = m_v;
    sb.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] ie);
    step(32'h0, 1'b0, 1'b0, ie, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_opcode"}, 32'(Opcode), 32'h0);
    chk({tag, "_immed"},  Immed, 32'h0);
    chk({tag, "_rf_a"},   RF_A,  32'h0);
    chk({tag, "_rf_b"},   RF_B,  32'h0);
    chk({tag, "_valid"},  32'(Instr_valid), 32'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check_zero("rst_async");
    model_clear();
    @(posedge Clk);
    #1;
    check_zero("rst_hold");
    @(negedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    logic [4:0] wa;
    int         wait_cnt;
    Instr = 0; IR_LdEn = 0; Flush = 0; ImmExt = 0; RF_WrEn = 0; RF_WrAddr = 0; RF_WrData = 0;
    model_clear();
    Reset = 1'b0;
    #1;
    check_zero("por");
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    idle(2'b00);

    // Operand read after write-back, 2-edge latency
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF);
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd6, 32'h12345678);
    step(32'h00A63020, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
    idle(2'b00);

    // Immediate modes
    step(32'h2001FFFC, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
    for (int m = 0; m < 4; m++) idle(2'(m));

    // Writes to reg 0 are dropped
    step(32'h00000000, 1'b1, 1'b0, 2'b00, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(32'h00000000, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 32'hFFFFFFFF);
    idle(2'b00);

    // Same-cycle write to the register being read
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'h00000001);
    step(32'h00A63020, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
    idle(2'b00);
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'hA5A5A5A5);
    idle(2'b00);

    // Flush beats load, then a clean load
    step(32'h8C220004, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0);
    step(32'h8C220004, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
    idle(2'b01);

    // Async reset with live state, then nothing until a load
    do_reset();
    idle(2'b00);
    step(32'h00A63020, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
    idle(2'b00);

    for (int n = 0; n < 400; n++) begin
      wa = ($urandom_range(0, 2) == 0) ? m_ir[25:21 - 0] : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) wa = m_ir[20:16];
      step($urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), wa, $urandom);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge Clk);
      wait_cnt++;
    end
    chk("drain", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
